// File: rtl/lsu_mem_port_if.sv
// Request/response handshake bundle between the load/store execute stage and its data-memory port.
// The master side issues requests and consumes responses.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_op;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_op, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_op, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Data-memory port: word RAM accessed at request acceptance, fixed-latency response pipe,
// and an in-order response FIFO guarded by outstanding-request credits.
module lsu_mem_port #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input logic           clk,
  input logic           reset,
  lsu_mem_port_if.slave bus
);
  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam int unsigned OutW      = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PtrW      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [32:0] AddrLimit = 33'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic        op;
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic  valid;
    resp_t resp;
  } slot_t;

  logic [31:0]     mem [DEPTH_WORDS];
  slot_t           pipe_q [LATENCY];
  resp_t           fifo_q [RESP_DEPTH];
  slot_t           slot_in;
  resp_t           head;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OutW-1:0] outst_q, outst_d, count_q, count_d;
  logic [IdxW-1:0] idx;
  logic            accept, pop, push, req_err;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(RESP_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign idx     = bus.req_addr[IdxW+1:2];
  assign req_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, bus.req_addr} >= AddrLimit);

  // Credits come only from registered state, so a same-cycle pop cannot raise ready.
  assign bus.req_ready  = outst_q < OutW'(RESP_DEPTH);
  assign accept         = bus.req_valid && bus.req_ready;
  assign push           = pipe_q[LATENCY-1].valid;
  assign bus.resp_valid = count_q != '0;
  assign pop            = bus.resp_valid && bus.resp_ready;

  assign head           = fifo_q[head_q];
  assign bus.resp_op    = bus.resp_valid & head.op;
  assign bus.resp_data  = {32{bus.resp_valid}} & head.data;
  assign bus.resp_err   = bus.resp_valid & head.err;

  always_comb begin
    slot_in          = '0;
    slot_in.valid    = accept;
    slot_in.resp.op  = bus.req_op;
    slot_in.resp.err = req_err;
    if (req_err) begin
      slot_in.resp.data = 32'h0;
    end else if (bus.req_op) begin
      slot_in.resp.data = bus.req_wdata;
    end else begin
      slot_in.resp.data = mem[idx];
    end
  end

  always_comb begin
    outst_d = outst_q;
    count_d = count_q;
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    case ({accept, pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      outst_q   <= outst_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      pipe_q[0] <= slot_in;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Storage is never reset; accepted stores survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && bus.req_op && !req_err) mem[idx] <= bus.req_wdata;
    if (!reset && push) fifo_q[tail_q] <= pipe_q[LATENCY-1].resp;
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: vector table plus hand-written multi-cycle sequences,
// with a response scoreboard filled on acceptance and drained on each pop.
module tb_lsu_mem_port;
  localparam int unsigned LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  lsu_mem_port_if bus ();

  lsu_mem_port #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT),
    .RESP_DEPTH (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] mdl [256];
  int          checks, failures, cyc, pops;
  bit          strict, use_exp;
  logic [31:0] x_data;
  logic        x_err;
  bit          s_acc, s_pop, s_ready, s_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  // One clock: sample at the falling edge, score pops and acceptances, then advance.
  task automatic step();
    exp_t        e;
    logic        merr;
    logic [31:0] a;
    @(negedge clk);
    s_ready = bus.req_ready;
    s_valid = bus.resp_valid;
    s_acc   = bus.req_valid && s_ready && !reset;
    s_pop   = s_valid && bus.resp_ready && !reset;
    if (s_pop) begin
      pops++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_op", {31'd0, bus.resp_op}, {31'd0, e.op});
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        if (strict) chk("resp_latency", cyc - e.acc, LAT);
      end
    end
    if (s_acc) begin
      a      = bus.req_addr;
      merr   = (a[1:0] != 2'b00) || (a >= 32'h400);
      e.op   = bus.req_op;
      e.acc  = cyc + 1;
      e.err  = merr;
      if (merr) e.data = 32'h0;
      else if (bus.req_op) begin
        e.data       = bus.req_wdata;
        mdl[a[9:2]]  = bus.req_wdata;
      end else e.data = mdl[a[9:2]];
      if (use_exp) begin
        e.data = x_data;
        e.err  = x_err;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) sb.delete();
  endtask

  task automatic drain(input int budget);
    idle();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() > 0; i++) step();
    chk("drain_empty", sb.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          n, gaps, drops, base;
    bit          after4, popped, credit_done;
    logic [31:0] bp [6];

    checks = 0; failures = 0; cyc = 0; pops = 0;
    strict = 1'b0; use_exp = 1'b0;
    idle();
    bus.resp_ready = 1'b1;

    // Reset values
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_op", {31'd0, bus.resp_op}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);

    // Vector table, back to back, exact latency expected
    vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h13,       32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h0,        32'h12345678, 32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 32'h400,      32'hCAFEF00D, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0,        32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 32'h3FC,      32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1'b0, 32'h3FC,      32'h0,        32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1'b1, 32'h2,        32'h11111111, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1});
    strict  = 1'b1;
    use_exp = 1'b1;
    foreach (vecs[i]) begin
      x_data = vecs[i].edata;
      x_err  = vecs[i].eerr;
      drive(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      step();
      chk("tbl_accept", {31'd0, s_acc}, 32'd1);
    end
    use_exp = 1'b0;
    drain(30);
    strict = 1'b0;

    // Backpressure: six loads against a stalled consumer
    bp = '{32'h10, 32'h0, 32'h3FC, 32'h10, 32'h0, 32'h3FC};
    bus.resp_ready = 1'b0;
    n = 0;
    after4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, bp[n], 32'h0);
      step();
      if (after4) chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
      if (s_acc) begin
        n++;
        if (n == 4) after4 = 1'b1;
      end
    end
    chk("bp_accepted", n, 4);
    bus.resp_ready = 1'b1;
    popped = 1'b0;
    credit_done = 1'b0;
    for (int i = 0; i < 12 && n < 6; i++) begin
      drive(1'b0, bp[n], 32'h0);
      step();
      if (popped && !credit_done) begin
        chk("credit_ready", {31'd0, s_ready}, 32'd1);
        chk("fifth_accept", {31'd0, s_acc}, 32'd1);
        credit_done = 1'b1;
      end
      if (s_pop && !popped) begin
        chk("ready_low_at_pop", {31'd0, s_ready}, 32'd0);
        popped = 1'b1;
      end
      if (s_acc) n++;
    end
    chk("bp_all_accepted", n, 6);
    drain(30);

    // Streaming stores then loads with an always-ready consumer
    strict = 1'b1;
    drops = 0;
    base = pops;
    for (int i = 0; i < 20; i++) begin
      if (i < 10) drive(1'b1, 32'(4 * i), 32'hA0000000 ^ (32'(i) * 32'h01010101));
      else        drive(1'b0, 32'(4 * (i - 10)), 32'h0);
      step();
      if (!s_ready || !s_acc) drops++;
    end
    drain(30);
    chk("stream_no_drop", drops, 0);
    chk("stream_resp_count", pops - base, 20);
    strict = 1'b0;

    // Full FIFO, then continuous request and consume
    bus.resp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6 && n < 4; i++) begin
      drive(1'b0, 32'(4 * n), 32'h0);
      step();
      if (s_acc) n++;
    end
    idle();
    repeat (LAT + 2) step();
    chk("full_ready_low", {31'd0, s_ready}, 32'd0);
    chk("full_resp_valid", {31'd0, s_valid}, 32'd1);
    bus.resp_ready = 1'b1;
    gaps = 0;
    base = pops;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'(4 * (i % 10)), 32'h0);
      step();
      if (!s_valid) gaps++;
    end
    chk("steady_no_gap", gaps, 0);
    chk("steady_pop_count", pops - base, 12);
    drain(30);

    // Reset with loads in flight
    drive(1'b1, 32'h20, 32'h5A5A1234);
    step();
    drain(20);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'(4 * i), 32'h0);
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    chk("midrst_resp_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, s_ready}, 32'd1);
    gaps = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_valid) gaps++;
    end
    chk("midrst_no_stale", gaps, 0);
    strict = 1'b1;
    drive(1'b0, 32'h20, 32'h0);
    step();
    drain(20);
    strict = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Data-memory port consumed by the load/store execute stage, occupying the dmem slot of the CPU pipeline.
- Accepts one load or store request per cycle over a ready/valid handshake.
- Performs the access on an internal word-addressed RAM, then returns in-order responses to the writeback stage over a second ready/valid handshake.
- Fixed access latency, a bounded response buffer and credit-based backpressure guarantee that no response is ever dropped.

Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words. Must be a power of two, at least 2.
- LATENCY, 2: cycles from request acceptance to response entering the buffer. Must be at least 1.
- RESP_DEPTH, 4: response FIFO entries. This is also the maximum number of outstanding requests. Must be at least 1.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  port can accept a request this cycle
- req_op  input  1  0 = load, 1 = store
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response at FIFO head
- resp_ready  input  1  consumer takes the response
- resp_op  output  1  op of the responding request
- resp_data  output  32  load data, or the stored data echoed for a store
- resp_err  output  1  request was misaligned or out of range

Behaviour:
- Acceptance: a request is accepted at a rising edge where req_valid && req_ready && !reset. At most one request is accepted per cycle.
- Outstanding count: outst counts accepted requests not yet popped, i.e. requests in the latency pipe plus entries in the FIFO. Width is clog2(RESP_DEPTH+1).
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
- req_ready = (outst < RESP_DEPTH). It is combinational from registered state only, with no dependence on req_valid.
  - When outst == RESP_DEPTH, a pop in the same cycle does NOT raise req_ready that cycle. The credit returns on the next cycle.
- Error check:
  - err = (req_addr[1:0] != 0) || (req_addr >= DEPTH_WORDS*4).
  - Word index = req_addr[clog2(DEPTH_WORDS)+1:2].
- Memory access at the acceptance edge:
  - Store with !err: RAM[index] <= req_wdata. The response data is req_wdata.
  - Load with !err: the RAM is read at the acceptance edge. A load accepted on the cycle after a store to the same word returns the new value.
  - err: no RAM write. Response data is 32'h0 and resp_err = 1.
- Latency pipe: LATENCY registered slots, each holding {valid, op, data, err}. The slot written at acceptance edge k reaches the FIFO at edge k+LATENCY.
  - The pipe never stalls. Credit accounting guarantees the FIFO has room at entry.
- Response FIFO: depth RESP_DEPTH, circular, with head/tail pointers wrapping modulo RESP_DEPTH.
  - resp_valid = !empty. resp_op, resp_data and resp_err are driven from the head entry.
  - Pop occurs when resp_valid && resp_ready.
  - Push and pop in the same cycle are legal, including when the FIFO is full or empty-with-push.
  - An empty-FIFO push is not bypassed: resp_valid asserts the cycle after the push edge.
- Minimum latency: with resp_ready held high, resp_valid is high in the cycle beginning at edge k+LATENCY for a request accepted at edge k. Responses come out in acceptance order.
- Reset values: req_ready=1, resp_valid=0, resp_op=0, resp_data=0, resp_err=0. outst=0, all pipe valids cleared, FIFO pointers zeroed.
- Reset mid-operation discards all in-flight and buffered responses. RAM contents are not reset, and stores already accepted remain in RAM. RAM initial contents are undefined.
- Values on req_op, req_addr and req_wdata are ignored while req_valid is 0.
- resp_op, resp_data and resp_err are don't-care while resp_valid is 0.

Test Plan:
- Store then load: store 0xDEADBEEF to 0x10, then load 0x10 on the next cycle, with resp_ready=1. Required: store response (op=1, data 0xDEADBEEF, err=0) 2 cycles after the store acceptance, then load response data 0xDEADBEEF one cycle later.
- Errors: load 0x13 -> err=1, data 0. Store 0x400 with DEPTH 256 -> err=1. A subsequent load of 0x0 returns the previously written value, not the 0x400 data.
- Backpressure: resp_ready=0, issue 6 back-to-back loads. Required: exactly 4 accepted and req_ready=0 from the cycle after the 4th acceptance.
  - Then raise resp_ready: responses drain in order, req_ready returns to 1 one cycle after the first pop, and the 5th request is accepted then.
- Streaming: resp_ready=1, stores to words 0..9 on consecutive cycles, then loads 0..9. Required: req_ready never drops, 20 in-order responses, and load data matches the stored data.
- Simultaneous events: with the FIFO full (outst=4), hold resp_ready=1 and req_valid=1 continuously. Required: FIFO count stays stable with one pop per cycle, each new response is pushed on the cycle its slot reaches the FIFO, and no response is lost or duplicated.
- Reset mid-flight: 3 loads outstanding, assert reset 1 cycle. Required: resp_valid=0 and req_ready=1 after reset, no stale responses appear, and a prior store's data is still readable.
